// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and helpers for the load/store unit.
// Latency: none (definitions only).
// Backpressure: n/a.
package lsu_pkg;

    // RV32I width codes carried in funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    // Request fields kept for the whole access
    typedef struct packed {
        logic        write;
        logic [2:0]  funct3;
        logic [1:0]  lane;
        logic [31:0] wdata;
    } lsu_req_t;

    // Stores only know B/H/W; loads additionally allow BU/HU
    function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
        if (write)
            return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    endfunction

    // funct3[1:0] is the access size for every legal code
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b01:   return lane[0];
            2'b10:   return lane != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Replace the addressed byte or halfword of a memory word with store data
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [31:0] m;
        m = word;
        if (f3 == F3_H) begin
            if (lane[1]) m[31:16] = wdata[15:0];
            else         m[15:0]  = wdata[15:0];
        end else begin
            case (lane)
                2'd0:    m[7:0]   = wdata[7:0];
                2'd1:    m[15:8]  = wdata[7:0];
                2'd2:    m[23:16] = wdata[7:0];
                default: m[31:24] = wdata[7:0];
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the byte/halfword lane of a memory word and sign/zero-extends it.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select, then extension chosen by the width code
    always_comb begin
        byte_sel = word[7:0];
        half_sel = lane[1] ? word[31:16] : word[15:0];
        data     = word;
        case (lane)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: word-aligned memory port, byte/half stores via read-modify-write.
// Latency: errors 1, loads/SW 2, SB/SH 3 enabled cycles from accept to o_rsp_valid.
// Backpressure: o_req_ready only in IDLE; one access in flight; i_clk_enable low freezes everything.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clk_enable,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [2:0]        i_req_funct3,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_misaligned,
    output logic              o_rsp_illegal,
    output logic              o_mem_write,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    lsu_state_t        state;
    lsu_req_t          req;
    logic              acc_ill;
    logic              acc_mis;
    logic [ADDR_W-1:0] acc_waddr;
    logic [31:0]       load_data;

    assign o_req_ready = (state == ST_IDLE);

    // Classification of the incoming request; illegal wins over misaligned
    assign acc_ill   = f3_illegal(i_req_write, i_req_funct3);
    assign acc_mis   = !acc_ill && f3_misaligned(i_req_funct3, i_req_addr[1:0]);
    assign acc_waddr = {i_req_addr[ADDR_W-1:2], 2'b00};

    // Formats the word currently being read using the latched width and lane
    lsu_load_align u_align (
        .word   (i_mem_rdata),
        .lane   (req.lane),
        .funct3 (req.funct3),
        .data   (load_data)
    );

    // Access FSM with all outputs registered; i_clk_enable low holds every register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state            <= ST_IDLE;
            req              <= '0;
            o_rsp_valid      <= 1'b0;
            o_rsp_rdata      <= '0;
            o_rsp_misaligned <= 1'b0;
            o_rsp_illegal    <= 1'b0;
            o_mem_write      <= 1'b0;
            o_mem_addr       <= '0;
            o_mem_wdata      <= '0;
        end else if (i_clk_enable) begin
            case (state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        req.write  <= i_req_write;
                        req.funct3 <= i_req_funct3;
                        req.lane   <= i_req_addr[1:0];
                        req.wdata  <= i_req_wdata;
                        if (acc_ill || acc_mis) begin
                            // Rejected accesses never touch memory
                            o_rsp_valid      <= 1'b1;
                            o_rsp_rdata      <= '0;
                            o_rsp_illegal    <= acc_ill;
                            o_rsp_misaligned <= acc_mis;
                            state            <= ST_RESP;
                        end else begin
                            o_mem_addr <= acc_waddr;
                            if (i_req_write && i_req_funct3 == F3_W) begin
                                // Full-word store needs no read
                                o_mem_wdata <= i_req_wdata;
                                o_mem_write <= 1'b1;
                                state       <= ST_WR;
                            end else begin
                                state <= ST_RD;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (req.write) begin
                        // Sub-word store: merge new lane into the word just read
                        o_mem_wdata <= store_merge(i_mem_rdata, req.wdata, req.funct3, req.lane);
                        o_mem_write <= 1'b1;
                        state       <= ST_WR;
                    end else begin
                        o_rsp_valid      <= 1'b1;
                        o_rsp_rdata      <= load_data;
                        o_rsp_misaligned <= 1'b0;
                        o_rsp_illegal    <= 1'b0;
                        state            <= ST_RESP;
                    end
                end
                ST_WR: begin
                    o_mem_write      <= 1'b0;
                    o_rsp_valid      <= 1'b1;
                    o_rsp_rdata      <= '0;
                    o_rsp_misaligned <= 1'b0;
                    o_rsp_illegal    <= 1'b0;
                    state            <= ST_RESP;
                end
                default: begin
                    // Response fields stay put until the next RESP
                    o_rsp_valid <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
